wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_mem_valid  input  1  MEM stage presents a real instruction (0 = bubble).
REQ-004 in_mem_wr_enable  input  1  instruction writes a GPR.
REQ-005 in_mem_wr_address  input  5  destination GPR.
REQ-006 in_mem_alu_result  input  32  ALU result or effective address for loads.
REQ-007 in_mem_is_load  input  1  GPR data comes from memory, not ALU.
REQ-008 in_mem_load_type  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101-111 reserved.
REQ-009 in_mem_load_data  input  32  raw aligned memory word, big-endian.
REQ-010 in_mem_hilo_we, in_mem_hi, in_mem_lo  input  1/32/32  HI/LO write request and values.
REQ-011 in_stall  input  1  MEM stalled while WB proceeds; WB shall capture a bubble.
REQ-012 in_flush  input  1  exception flush; WB shall capture a bubble.
REQ-013 out_wr_enable, out_wr_address, out_wr_data  output  1/5/32  register-file write port.
REQ-014 out_hi, out_lo  output  32/32  architectural HI/LO registers.
REQ-015 out_addr_error  output  1  one-cycle pulse: misaligned or reserved load dropped.
REQ-016 out_retired  output  32  count of instructions retired.

Function
REQ-017 All outputs shall be registers; latency MEM input -> WB output is exactly one clock.
REQ-018 Edge priority shall be: in_flush, then in_stall, then normal capture.
REQ-019 On flush or stall edge: out_wr_enable=0, out_wr_address=0, out_wr_data=0, out_addr_error=0; HI/LO and out_retired hold.
REQ-020 Normal capture with in_mem_valid=0 shall behave exactly as REQ-019.
REQ-021 Normal capture with in_mem_valid=1: out_wr_address=in_mem_wr_address; out_wr_enable=in_mem_wr_enable AND (address!=0) AND no load error.
REQ-022 Non-load: out_wr_data=in_mem_alu_result.
REQ-023 Load byte offset off=in_mem_alu_result[1:0]; byte off 0 = data[31:24], off 3 = data[7:0].
REQ-024 LW: data unchanged; off!=0 is an error.
REQ-025 LB/LBU: selected byte, sign- or zero-extended to 32; never an error.
REQ-026 LH/LHU: off[1]=0 -> data[31:16], off[1]=1 -> data[15:0], sign-/zero-extended; off[0]=1 is an error.
REQ-027 Reserved load_type is an error.
REQ-028 On error: out_wr_enable=0, out_wr_data=0, out_addr_error=1 for that cycle only; the instruction still counts as retired.
REQ-029 in_mem_hilo_we=1 on a valid capture shall load out_hi/out_lo the same edge; it is independent of GPR write and load error.
REQ-030 out_retired shall increment by 1 per valid capture and wrap from 0xFFFFFFFF to 0.
REQ-031 Inputs are don't-care when in_mem_valid=0, in_stall=1 or in_flush=1.

Reset
REQ-032 rst_n low shall immediately clear every output, HI/LO and out_retired to 0, regardless of clk.
REQ-033 First capture shall occur on the first rising edge with rst_n high; an instruction presented during reset is discarded.

Verification
REQ-034 Valid add, wr_address=5, alu_result=0x12345678 -> next cycle wr_enable=1, addr=5, data=0x12345678, retired=1.
REQ-035 LB, load_data=0x80FF7F01, off=0 -> data=0xFFFFFF80. LBU off=1 -> 0x000000FF. LH off=2 -> 0x00007F01. LHU off=0 -> 0x000080FF.
REQ-036 LW off=2 -> wr_enable=0, data=0, addr_error=1 for one cycle, retired increments. Next valid instruction -> addr_error=0.
REQ-037 wr_address=0 with wr_enable=1 -> out_wr_enable=0. The same cycle with hilo_we=1, hi=0xA, lo=0xB -> out_hi=0xA, out_lo=0xB.
REQ-038 Flush and stall asserted together with a valid write -> bubble, HI/LO and retired unchanged. Stall alone -> bubble.
REQ-039 Preload retired=0xFFFFFFFF, then a valid capture -> 0. Assert rst_n low mid-stream between edges -> all outputs 0 at once.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle: instruction fields coming out of MEM and the architectural
// results that the write-back stage produces.
interface wb_stage_if;
    logic        in_mem_valid;
    logic        in_mem_wr_enable;
    logic [4:0]  in_mem_wr_address;
    logic [31:0] in_mem_alu_result;
    logic        in_mem_is_load;
    logic [2:0]  in_mem_load_type;
    logic [31:0] in_mem_load_data;
    logic        in_mem_hilo_we;
    logic [31:0] in_mem_hi;
    logic [31:0] in_mem_lo;
    logic        in_stall;
    logic        in_flush;
    logic        out_wr_enable;
    logic [4:0]  out_wr_address;
    logic [31:0] out_wr_data;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic        out_addr_error;
    logic [31:0] out_retired;

    modport master (
        output in_mem_valid, in_mem_wr_enable, in_mem_wr_address, in_mem_alu_result,
               in_mem_is_load, in_mem_load_type, in_mem_load_data,
               in_mem_hilo_we, in_mem_hi, in_mem_lo, in_stall, in_flush,
        input  out_wr_enable, out_wr_address, out_wr_data, out_hi, out_lo,
               out_addr_error, out_retired
    );

    modport slave (
        input  in_mem_valid, in_mem_wr_enable, in_mem_wr_address, in_mem_alu_result,
               in_mem_is_load, in_mem_load_type, in_mem_load_data,
               in_mem_hilo_we, in_mem_hi, in_mem_lo, in_stall, in_flush,
        output out_wr_enable, out_wr_address, out_wr_data, out_hi, out_lo,
               out_addr_error, out_retired
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: load alignment/extension, GPR write port, HI/LO and retire
// counter, all registered one clock after MEM.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    wb_stage_if.slave   bus
);
    // Returns {error, extended data}; loads are big-endian, byte 0 is word[31:24].
    function automatic logic [32:0] load_extract(input logic [2:0]  load_type,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [32:0] res_v;
        case (off)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[15:0] : word[31:16];
        case (load_type)
            3'b000:  res_v = (off == 2'b00) ? {1'b0, word} : {1'b1, 32'h0000_0000};
            3'b001:  res_v = {1'b0, {24{byte_v[7]}}, byte_v};
            3'b010:  res_v = {1'b0, 24'h00_0000, byte_v};
            3'b011:  res_v = off[0] ? {1'b1, 32'h0000_0000} : {1'b0, {16{half_v[15]}}, half_v};
            3'b100:  res_v = off[0] ? {1'b1, 32'h0000_0000} : {1'b0, 16'h0000, half_v};
            default: res_v = {1'b1, 32'h0000_0000};
        endcase
        return res_v;
    endfunction

    logic        capture_s;
    logic [32:0] load_res_s;
    logic        load_err_s;
    logic        wr_enable_nx_s;
    logic [4:0]  wr_address_nx_s;
    logic [31:0] wr_data_nx_s;
    logic        addr_error_nx_s;
    logic        hilo_load_s;

    logic        wr_enable_r;
    logic [4:0]  wr_address_r;
    logic [31:0] wr_data_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        addr_error_r;
    logic [31:0] retired_r;

    // Next-state of the write port; flush, stall and bubbles all collapse to a zero write.
    always_comb begin
        capture_s       = bus.in_mem_valid & ~bus.in_flush & ~bus.in_stall;
        load_res_s      = load_extract(bus.in_mem_load_type, bus.in_mem_alu_result[1:0],
                                       bus.in_mem_load_data);
        load_err_s      = bus.in_mem_is_load & load_res_s[32];
        wr_enable_nx_s  = 1'b0;
        wr_address_nx_s = 5'd0;
        wr_data_nx_s    = 32'h0000_0000;
        addr_error_nx_s = 1'b0;
        hilo_load_s     = 1'b0;
        if (capture_s) begin
            wr_address_nx_s = bus.in_mem_wr_address;
            addr_error_nx_s = load_err_s;
            hilo_load_s     = bus.in_mem_hilo_we;
            wr_enable_nx_s  = bus.in_mem_wr_enable & (bus.in_mem_wr_address != 5'd0) & ~load_err_s;
            if (load_err_s) begin
                wr_data_nx_s = 32'h0000_0000;
            end else if (bus.in_mem_is_load) begin
                wr_data_nx_s = load_res_s[31:0];
            end else begin
                wr_data_nx_s = bus.in_mem_alu_result;
            end
        end else begin
            wr_address_nx_s = 5'd0;
        end
    end

    // Architectural state: write port, HI/LO and the wrapping retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_enable_r  <= 1'b0;
            wr_address_r <= 5'd0;
            wr_data_r    <= 32'h0000_0000;
            addr_error_r <= 1'b0;
            hi_r         <= 32'h0000_0000;
            lo_r         <= 32'h0000_0000;
            retired_r    <= 32'h0000_0000;
        end else begin
            wr_enable_r  <= wr_enable_nx_s;
            wr_address_r <= wr_address_nx_s;
            wr_data_r    <= wr_data_nx_s;
            addr_error_r <= addr_error_nx_s;
            if (hilo_load_s) begin
                hi_r <= bus.in_mem_hi;
                lo_r <= bus.in_mem_lo;
            end
            if (capture_s) begin
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    assign bus.out_wr_enable  = wr_enable_r;
    assign bus.out_wr_address = wr_address_r;
    assign bus.out_wr_data    = wr_data_r;
    assign bus.out_addr_error = addr_error_r;
    assign bus.out_hi         = hi_r;
    assign bus.out_lo         = lo_r;
    assign bus.out_retired    = retired_r;
endmodule
